// File: rtl/led_mode_ctrl_pkg.sv
// led_mode_ctrl_pkg: mode encodings and shared widths for the LED mode controller
package led_mode_ctrl_pkg;
  localparam int DUTY_W = 10;
  localparam int BLINK_MS = 250;
  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BREATHE, MODE_BLINK} mode_t;
endpackage

// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: raw key inputs and duty/mode/speed outputs of the LED mode controller
interface led_mode_ctrl_if;
  import led_mode_ctrl_pkg::*;
  logic key_mode_n;
  logic key_speed_n;
  logic [DUTY_W-1:0] duty;
  logic duty_vld;
  logic [1:0] mode;
  logic [1:0] speed;
  modport master (input key_mode_n, key_speed_n, output duty, duty_vld, mode, speed);
  modport slave (output key_mode_n, key_speed_n, input duty, duty_vld, mode, speed);
endinterface

// File: rtl/led_mode_ctrl_key_debounce.sv
// key_debounce: 2-FF sync, ms-tick debounce, 1-clk press pulse on accepted release->press edge
module key_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_MS - 1);
  logic [1:0] sync;
  logic acc;
  logic hit;
  logic [CW-1:0] cnt;
  assign hit = ms_tick && sync[1] != acc && cnt == LAST;
  assign press = hit && !sync[1];
  // Count only on ms ticks; a tick that sees the accepted level again restarts the run.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      acc <= 1'b1;
      cnt <= '0;
    end else begin
      sync <= {sync[0], key_n};
      if (ms_tick) cnt <= (sync[1] == acc || hit) ? '0 : cnt + 1'b1;
      if (hit) acc <= sync[1];
    end
endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced mode/speed keys driving the OFF/ON/BREATHE/BLINK duty set-point
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 50,
  parameter int US_PER_MS = 1000,
  parameter int DEB_MS    = 20,
  parameter int DUTY_MAX  = 999,
  parameter int DUTY_STEP = 1
) (
  input logic clk,
  input logic rst_n,
  led_mode_ctrl_if.master bus
);
  localparam int UW = $clog2(TICK_DIV + 1);
  localparam int MW = $clog2(US_PER_MS + 1);
  localparam int IW = $clog2(BLINK_MS * 4 + 1);
  localparam int DW1 = DUTY_W + 1;
  localparam logic [UW-1:0] US_LAST = UW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MS_LAST = MW'(US_PER_MS - 1);
  localparam logic [DUTY_W-1:0] DMAX = DUTY_W'(DUTY_MAX);
  localparam logic [DW1-1:0] STEP = DW1'(DUTY_STEP);
  logic [UW-1:0] us_cnt;
  logic [MW-1:0] ms_cnt;
  logic [IW-1:0] int_cnt, int_n, lim;
  logic us_tick, ms_tick, press_mode, press_speed, expire;
  logic up, up_n, vld, vld_n;
  logic [DUTY_W-1:0] duty, duty_n;
  logic [DW1-1:0] nxt;
  logic [1:0] speed;
  mode_t mode, mode_n;
  assign us_tick = us_cnt == US_LAST;
  assign ms_tick = us_tick && ms_cnt == MS_LAST;
  key_debounce #(.DEB_MS(DEB_MS)) u_key_mode (
    .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .key_n(bus.key_mode_n), .press(press_mode)
  );
  key_debounce #(.DEB_MS(DEB_MS)) u_key_speed (
    .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .key_n(bus.key_speed_n), .press(press_speed)
  );
  // mode[1] marks the two periodic modes (BREATHE, BLINK); any key press restarts the interval.
  always_comb begin
    lim = mode == MODE_BLINK ? IW'(BLINK_MS * (int'(speed) + 1) - 1) : IW'(speed);
    expire = ms_tick && mode[1] && int_cnt == lim;
    nxt = {1'b0, duty} + STEP;
    mode_n = press_mode ? mode_t'(mode + 2'd1) : mode;
    int_n = (press_mode || press_speed || expire) ? '0 : (ms_tick && mode[1]) ? int_cnt + 1'b1 : int_cnt;
    duty_n = duty;
    up_n = up;
    vld_n = 1'b0;
    if (press_mode) begin
      duty_n = mode_n[0] ? DMAX : '0;
      up_n = 1'b1;
      vld_n = 1'b1;
    end else if (expire && !press_speed) begin
      vld_n = 1'b1;
      if (mode == MODE_BLINK) duty_n = duty == '0 ? DMAX : '0;
      else if (up) begin
        duty_n = nxt >= {1'b0, DMAX} ? DMAX : nxt[DUTY_W-1:0];
        up_n = nxt < {1'b0, DMAX};
      end else begin
        duty_n = {1'b0, duty} <= STEP ? '0 : duty - STEP[DUTY_W-1:0];
        up_n = {1'b0, duty} <= STEP;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      us_cnt <= '0;
      ms_cnt <= '0;
      int_cnt <= '0;
      mode <= MODE_BREATHE;
      speed <= '0;
      duty <= '0;
      up <= 1'b1;
      vld <= 1'b0;
    end else begin
      us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
      if (us_tick) ms_cnt <= ms_tick ? '0 : ms_cnt + 1'b1;
      int_cnt <= int_n;
      mode <= mode_n;
      speed <= speed + {1'b0, press_speed};
      duty <= duty_n;
      up <= up_n;
      vld <= vld_n;
    end
  assign bus.duty = duty;
  assign bus.duty_vld = vld;
  assign bus.mode = mode;
  assign bus.speed = speed;
endmodule
